// File: rtl/clint_trap_ctrl.sv
// -----------------------------------------------------------------------------
// clint_trap_ctrl
// Trap sequencer on the CLINT side of the CSR file. Accepts ECALL, MRET and
// machine timer/external interrupts. For traps it writes MEPC, MCAUSE and
// MSTATUS through the CLINT write port. For MRET it writes MSTATUS only. It
// then redirects fetch to the trap handler (traps) or back to MEPC (MRET).
// The pipeline is stalled for the whole sequence.
//
// Optional feature macro: CLINT_VECTORED_EN
//   When defined, interrupts use vectored entry whenever mtvec[1:0] == 2'b01.
//   When undefined, every trap goes to the direct base address.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   ecall_ex, mret_ex   ECALL / MRET instruction valid in EX
//   pc_ex, pc_next_ex   EX PC (MEPC for ECALL) / next PC (MEPC for interrupts)
//   irq_timer, irq_ext  machine timer / external interrupt levels
//   csr_we_ex           EX-stage CSR write; takes priority at the CSR file
//   clint_csr_*         current mstatus / mepc / mtvec values
//   interrupt_enable    mstatus.MIE
//   we_clint, wa_clint, wd_clint   CSR write port (enable / address / data)
//   stall, flush        pipeline freeze / one-cycle IF-ID-EX kill
//   pc_redirect         one-cycle PC load strobe
//   redirect_pc         PC load value (RESET_PC while idle)
//   busy                sequencer is not in IDLE
// -----------------------------------------------------------------------------
module clint_trap_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ecall_ex,
  input  logic        mret_ex,
  input  logic [31:0] pc_ex,
  input  logic [31:0] pc_next_ex,
  input  logic        irq_timer,
  input  logic        irq_ext,
  input  logic        csr_we_ex,
  input  logic [31:0] clint_csr_mstatus,
  input  logic [31:0] clint_csr_mepc,
  input  logic [31:0] clint_csr_mtvec,
  input  logic        interrupt_enable,
  output logic        we_clint,
  output logic [11:0] wa_clint,
  output logic [31:0] wd_clint,
  output logic        stall,
  output logic        flush,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  // CSR addresses shared with the CSR file
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] CAUSE_ECALL = 32'h0000_000B;
  localparam logic [31:0] CAUSE_EXT   = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_W_MEPC    = 3'd1,
    S_W_MCAUSE  = 3'd2,
    S_W_MSTATUS = 3'd3,
    S_M_MSTATUS = 3'd4,
    S_REDIRECT  = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] save_pc_q, save_pc_d;
  logic [31:0] cause_q, cause_d;
  logic        mret_q, mret_d;
  logic        accept;

  logic [31:0] mstatus_trap;
  logic [31:0] mstatus_mret;
  logic [31:0] trap_base;
  logic [31:0] trap_target;

  // mstatus images for trap entry and MRET
  always_comb begin
    mstatus_trap        = clint_csr_mstatus;
    mstatus_trap[7]     = clint_csr_mstatus[3];
    mstatus_trap[3]     = 1'b0;
    mstatus_trap[12:11] = 2'b11;

    mstatus_mret        = clint_csr_mstatus;
    mstatus_mret[3]     = clint_csr_mstatus[7];
    mstatus_mret[7]     = 1'b1;
    mstatus_mret[12:11] = 2'b11;
  end

  assign trap_base = {clint_csr_mtvec[31:2], 2'b00};

`ifdef CLINT_VECTORED_EN
  // Vectored entry applies to interrupts only (cause MSB set)
  always_comb begin
    trap_target = trap_base;
    if (cause_q[31] && (clint_csr_mtvec[1:0] == 2'b01)) begin
      trap_target = trap_base + (32'(cause_q[30:0]) << 2);
    end
  end
`else
  // Direct mode: the mode bits of mtvec carry no meaning here
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^clint_csr_mtvec[1:0];
  assign trap_target       = trap_base;
`endif

  // State and event context registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      save_pc_q <= 32'h0;
      cause_q   <= 32'h0;
      mret_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      save_pc_q <= save_pc_d;
      cause_q   <= cause_d;
      mret_q    <= mret_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    save_pc_d   = save_pc_q;
    cause_d     = cause_q;
    mret_d      = mret_q;
    accept      = 1'b0;
    we_clint    = 1'b0;
    wa_clint    = 12'h0;
    wd_clint    = 32'h0;
    pc_redirect = 1'b0;
    redirect_pc = RESET_PC;

    unique case (state_q)
      S_IDLE: begin
        // Gated by rst so flush/stall stay low while reset is held
        if (!rst) begin
          if (ecall_ex) begin
            accept    = 1'b1;
            save_pc_d = pc_ex;
            cause_d   = CAUSE_ECALL;
            mret_d    = 1'b0;
            state_d   = S_W_MEPC;
          end else if (mret_ex) begin
            accept  = 1'b1;
            mret_d  = 1'b1;
            state_d = S_M_MSTATUS;
          end else if (interrupt_enable && irq_ext) begin
            accept    = 1'b1;
            save_pc_d = pc_next_ex;
            cause_d   = CAUSE_EXT;
            mret_d    = 1'b0;
            state_d   = S_W_MEPC;
          end else if (interrupt_enable && irq_timer) begin
            accept    = 1'b1;
            save_pc_d = pc_next_ex;
            cause_d   = CAUSE_TIMER;
            mret_d    = 1'b0;
            state_d   = S_W_MEPC;
          end
        end
      end
      S_W_MEPC: begin
        we_clint = 1'b1;
        wa_clint = CSR_MEPC;
        wd_clint = save_pc_q;
        if (!csr_we_ex) state_d = S_W_MCAUSE;
      end
      S_W_MCAUSE: begin
        we_clint = 1'b1;
        wa_clint = CSR_MCAUSE;
        wd_clint = cause_q;
        if (!csr_we_ex) state_d = S_W_MSTATUS;
      end
      S_W_MSTATUS: begin
        we_clint = 1'b1;
        wa_clint = CSR_MSTATUS;
        wd_clint = mstatus_trap;
        if (!csr_we_ex) state_d = S_REDIRECT;
      end
      S_M_MSTATUS: begin
        we_clint = 1'b1;
        wa_clint = CSR_MSTATUS;
        wd_clint = mstatus_mret;
        if (!csr_we_ex) state_d = S_REDIRECT;
      end
      S_REDIRECT: begin
        pc_redirect = 1'b1;
        redirect_pc = mret_q ? clint_csr_mepc : trap_target;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy  = (state_q != S_IDLE);
  assign flush = accept;
  assign stall = busy | accept;

endmodule
